fifo_enq_arbiter: RTL and testbench

FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

---
 rtl/fifo_enq_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_enq_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter that grants one requester at a time onto a single FIFO enqueue port.
// A grant lasts up to BURST beats or until the granted requester drops its valid.
module fifo_enq_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_val,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_rdy,
    output logic                  fifo_enq_val,
    output logic [WIDTH-1:0]      fifo_enq_data,
    input  logic                  fifo_enq_rdy,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr, rr_ptr_next;
    logic [IW-1:0]   grant_id_next;
    logic [7:0]      cnt, cnt_next;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            found;
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // NREQ is a power of two, so IW-bit addition wraps exactly modulo NREQ.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = rr_ptr + IW'(i);
            if (!found && req_val[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        cnt_next      = cnt;
        grant_id_next = grant_id;
        fifo_enq_val  = 1'b0;
        fifo_enq_data = '0;
        req_rdy       = '0;
        busy          = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_id_next = pick;
                    cnt_next      = 8'd0;
                    state_next    = GRANT;
                end
            end
            GRANT: begin
                busy              = 1'b1;
                fifo_enq_val      = req_val[grant_id];
                fifo_enq_data     = data_arr[grant_id];
                req_rdy[grant_id] = fifo_enq_rdy;
                if (!req_val[grant_id]) begin
                    state_next  = IDLE;
                    rr_ptr_next = grant_id + 1'b1;
                end else if (fifo_enq_rdy) begin
                    cnt_next = cnt + 8'd1;
                    if (cnt + 8'd1 == 8'(BURST)) begin
                        state_next  = IDLE;
                        rr_ptr_next = grant_id + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            cnt      <= 8'd0;
            grant_id <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            cnt      <= cnt_next;
            grant_id <= grant_id_next;
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Directed bench for fifo_enq_arbiter: default instance (BURST=4) and a BURST=1 instance,
// each with a beat scoreboard fed by the driver and drained by a negedge monitor.
module tb_fifo_enq_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_val, req_rdy;
    logic [31:0] req_data;
    logic        fifo_enq_val, fifo_enq_rdy, busy;
    logic [7:0]  fifo_enq_data;
    logic [1:0]  grant_id;

    logic [3:0]  b1_req_val, b1_req_rdy;
    logic [31:0] b1_req_data;
    logic        b1_fifo_enq_val, b1_fifo_enq_rdy, b1_busy;
    logic [7:0]  b1_fifo_enq_data;
    logic [1:0]  b1_grant_id;

    int tests_run = 0;
    int tests_failed = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp1_q[$];

    fifo_enq_arbiter #(.WIDTH(8), .NREQ(4), .BURST(4)) dut (
        .clk(clk), .reset(reset), .req_val(req_val), .req_data(req_data),
        .req_rdy(req_rdy), .fifo_enq_val(fifo_enq_val), .fifo_enq_data(fifo_enq_data),
        .fifo_enq_rdy(fifo_enq_rdy), .grant_id(grant_id), .busy(busy)
    );

    fifo_enq_arbiter #(.WIDTH(8), .NREQ(4), .BURST(1)) dut_b1 (
        .clk(clk), .reset(reset), .req_val(b1_req_val), .req_data(b1_req_data),
        .req_rdy(b1_req_rdy), .fifo_enq_val(b1_fifo_enq_val), .fifo_enq_data(b1_fifo_enq_data),
        .fifo_enq_rdy(b1_fifo_enq_rdy), .grant_id(b1_grant_id), .busy(b1_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester i presents base+i.
    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = base + 8'(i);
    endtask

    task automatic push_beats(input logic [1:0] id, input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({id, data});
    endtask

    task automatic enter_reset();
        reset = 1'b0;
        req_val = 4'b0;
        b1_req_val = 4'b0;
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && exp1_q.size() == 0) break;
            tick();
        end
        check({name, "_drain"}, 32'(exp_q.size() + exp1_q.size()), 32'd0);
        exp_q.delete();
        exp1_q.delete();
    endtask

    // Scoreboard monitors: pop on every accepted beat, and check idle outputs stay quiet.
    always @(negedge clk) begin
        if (reset && fifo_enq_val && fifo_enq_rdy) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_beat: got id %0d data 0x%0h expected none", grant_id, fifo_enq_data);
            end else begin
                check("beat", {22'd0, grant_id, fifo_enq_data}, {22'd0, exp_q.pop_front()});
            end
        end
        if (reset && !busy)
            check("idle_outputs", {19'd0, fifo_enq_val, req_rdy, fifo_enq_data}, 32'd0);
    end

    always @(negedge clk) begin
        if (reset && b1_fifo_enq_val && b1_fifo_enq_rdy) begin
            if (exp1_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_beat_b1: got id %0d data 0x%0h expected none", b1_grant_id, b1_fifo_enq_data);
            end else begin
                check("beat_b1", {22'd0, b1_grant_id, b1_fifo_enq_data}, {22'd0, exp1_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_val = 4'b0;
        req_data = 32'd0;
        fifo_enq_rdy = 1'b1;
        b1_req_val = 4'b0;
        b1_req_data = 32'd0;
        b1_fifo_enq_rdy = 1'b1;
        tick();

        // Reset state, and IDLE holds with no requests.
        req_val = 4'b1111;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_outs", {19'd0, fifo_enq_val, req_rdy, fifo_enq_data}, 32'd0);
        tick();
        check("rst_hold_busy", 32'(busy), 32'd0);
        req_val = 4'b0;
        reset = 1'b1;
        tick();
        tick();
        check("idle_noreq_busy", 32'(busy), 32'd0);
        check("idle_noreq_gid", 32'(grant_id), 32'd0);

        // req1 and req2 from reset: 4 beats each with one IDLE cycle between.
        enter_reset();
        set_data(8'h10);
        req_val = 4'b0110;
        reset = 1'b1;
        push_beats(2'd1, 8'h11, 4);
        push_beats(2'd2, 8'h12, 4);
        tick();
        check("a_first_busy", 32'(busy), 32'd1);
        check("a_first_gid", 32'(grant_id), 32'd1);
        repeat (4) tick();
        check("a_gap_busy", 32'(busy), 32'd0);
        tick();
        check("a_second_busy", 32'(busy), 32'd1);
        check("a_second_gid", 32'(grant_id), 32'd2);
        repeat (4) tick();
        req_val = 4'b0;
        drain("a");

        // All four requesting: order 0,1,2,3,0 with a single IDLE cycle between grants.
        enter_reset();
        set_data(8'h20);
        req_val = 4'b1111;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) push_beats(2'(k % 4), 8'h20 + 8'(k % 4), 4);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("b_grant_busy", 32'(busy), 32'd1);
            check("b_grant_gid", 32'(grant_id), 32'(k % 4));
            repeat (4) tick();
            check("b_gap_busy", 32'(busy), 32'd0);
            if (k == 4) req_val = 4'b0;
        end
        drain("b");

        // Back-pressure after beat 2 holds the grant without counting.
        enter_reset();
        set_data(8'h30);
        req_val = 4'b0001;
        reset = 1'b1;
        push_beats(2'd0, 8'h30, 4);
        repeat (3) tick();
        fifo_enq_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("c_hold_busy", 32'(busy), 32'd1);
            check("c_hold_rdy", 32'(req_rdy), 32'd0);
            tick();
        end
        fifo_enq_rdy = 1'b1;
        tick();
        check("c_resume_busy", 32'(busy), 32'd1);
        tick();
        check("c_end_busy", 32'(busy), 32'd0);
        req_val = 4'b0;
        drain("c");

        // req3 drops after beat 1: IDLE next, pointer wraps to 0.
        enter_reset();
        set_data(8'h40);
        req_val = 4'b1000;
        reset = 1'b1;
        push_beats(2'd3, 8'h43, 1);
        tick();
        check("d_gid3", 32'(grant_id), 32'd3);
        tick();
        req_val = 4'b0000;
        tick();
        check("d_idle_busy", 32'(busy), 32'd0);
        check("d_idle_val", 32'(fifo_enq_val), 32'd0);
        req_val = 4'b1001;
        tick();
        check("d_wrap_gid", 32'(grant_id), 32'd0);
        req_val = 4'b0;
        tick();
        drain("d");

        // Asynchronous reset mid-burst, then restart from requester 0.
        enter_reset();
        set_data(8'h50);
        req_val = 4'b0100;
        reset = 1'b1;
        push_beats(2'd2, 8'h52, 2);
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check("e_rst_busy", 32'(busy), 32'd0);
        check("e_rst_gid", 32'(grant_id), 32'd0);
        check("e_rst_outs", {19'd0, fifo_enq_val, req_rdy, fifo_enq_data}, 32'd0);
        tick();
        req_val = 4'b1000;
        tick();
        reset = 1'b1;
        push_beats(2'd3, 8'h53, 4);
        tick();
        check("e_gid3", 32'(grant_id), 32'd3);
        check("e_busy", 32'(busy), 32'd1);
        repeat (4) tick();
        req_val = 4'b0;
        drain("e");

        // BURST=1 instance: single beats alternating 0,1,0,1.
        enter_reset();
        for (int i = 0; i < 4; i++) b1_req_data[i*8 +: 8] = 8'h60 + 8'(i);
        b1_req_val = 4'b0011;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) exp1_q.push_back({2'(k % 2), 8'h60 + 8'(k % 2)});
        for (int k = 0; k < 4; k++) begin
            tick();
            check("f_grant_busy", 32'(b1_busy), 32'd1);
            check("f_grant_gid", 32'(b1_grant_id), 32'(k % 2));
            tick();
            check("f_gap_busy", 32'(b1_busy), 32'd0);
            if (k == 3) b1_req_val = 4'b0;
        end
        drain("f");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
